// File: rtl/s12bcd_pkg.sv
// s12bcd_pkg: shared constants, FSM state type and the double-dabble digit
// adjust helper for the round-robin signed-12-bit-to-BCD controller.
package s12bcd_pkg;

  localparam int DATA_W = 12;  // width of the two's-complement input word
  localparam int DIGITS = 4;   // packed BCD digits produced
  localparam int ITER   = 12;  // shift iterations, one per magnitude bit

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Shift-add-3 correction: a digit of 5..9 would become >= 10 after the
  // doubling shift, so it is pre-biased by 3. Input never exceeds 9, so the
  // result fits in the nibble.
  function automatic logic [3:0] add3_adjust(input logic [3:0] nibble);
    logic [3:0] res;
    if (nibble > 4'd4) begin
      res = nibble + 4'd3;
    end else begin
      res = nibble;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_dd_core.sv
// bcd_dd_core: 16-bit double-dabble digit register and single iteration step.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the digit register (start of a conversion, wins over step)
//   step       : perform one adjust-and-shift iteration this cycle
//   bit_in     : magnitude bit shifted into the ones digit LSB
//   digits     : {thousands, hundreds, tens, ones}
module bcd_dd_core
  import s12bcd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  step,
  input  logic                  bit_in,
  output logic [4*DIGITS-1:0]   digits
);

  logic [4*DIGITS-1:0] digits_r;
  logic [4*DIGITS-1:0] adj_s;

  // Apply the +3 correction to every digit before the shift.
  always_comb begin
    adj_s = '0;
    for (int d = 0; d < DIGITS; d++) begin
      adj_s[4*d +: 4] = add3_adjust(digits_r[4*d +: 4]);
    end
  end

  // Digit register: clear, shift in the next magnitude bit, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_r <= '0;
    end else if (clr) begin
      digits_r <= '0;
    end else if (step) begin
      digits_r <= {adj_s[4*DIGITS-2:0], bit_in};
    end else begin
      digits_r <= digits_r;
    end
  end

  assign digits = digits_r;

endmodule

// File: rtl/s12bcd_rr_ctrl.sv
// s12bcd_rr_ctrl: round-robin arbiter sharing one sequential signed-12-bit to
// BCD (double-dabble) engine among NREQ requesters.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request level, held until its gnt bit
//   req_data   : packed signed words, requester k at [12k+11:12k]
//   gnt        : one-hot one-cycle grant; req_data captured on that edge
//   busy       : high from the grant edge until done deasserts
//   done       : one-cycle result-valid pulse
//   done_id    : requester id of the presented result
//   sign       : sign of the converted word
//   bcd        : magnitude as {thousands, hundreds, tens, ones}
module s12bcd_rr_ctrl
  import s12bcd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic                   done,
  output logic [IDW-1:0]         done_id,
  output logic                   sign,
  output logic [4*DIGITS-1:0]    bcd
);

  state_t              state_r;
  logic [IDW-1:0]      ptr_r;
  logic [IDW-1:0]      id_r;
  logic [DATA_W-1:0]   mag_r;
  logic [3:0]          cnt_r;
  logic                sign_cur_r;

  logic [NREQ-1:0]     gnt_r;
  logic                busy_r;
  logic                done_r;
  logic [IDW-1:0]      done_id_r;
  logic                sign_r;
  logic [4*DIGITS-1:0] bcd_r;

  logic [DATA_W-1:0]   words_s [NREQ];
  logic                win_found_s;
  logic [IDW-1:0]      win_idx_s;
  int                  cand_s;
  logic [DATA_W-1:0]   win_word_s;
  logic [DATA_W-1:0]   win_mag_s;
  logic                clr_s;
  logic                step_s;
  logic                bit_in_s;
  logic [4*DIGITS-1:0] digits_s;

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign words_s[k] = req_data[k*DATA_W +: DATA_W];
  end

  // Round-robin pick: first requester found scanning upward from ptr+1 with wrap.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = (int'(ptr_r) + i) % NREQ;
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDW'(cand_s);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Winner's word and its magnitude; 0x800 maps to 2048 as a 12-bit unsigned value.
  always_comb begin
    win_word_s = words_s[win_idx_s];
    if (win_word_s[DATA_W-1]) begin
      win_mag_s = ~win_word_s + 12'd1;
    end else begin
      win_mag_s = win_word_s;
    end
  end

  assign clr_s    = (state_r == IDLE) && win_found_s;
  assign step_s   = (state_r == CONV);
  assign bit_in_s = mag_r[cnt_r];

  bcd_dd_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_s),
    .step   (step_s),
    .bit_in (bit_in_s),
    .digits (digits_s)
  );

  // Arbitration / conversion FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= IDW'(NREQ - 1);
      id_r       <= '0;
      mag_r      <= '0;
      cnt_r      <= 4'd0;
      sign_cur_r <= 1'b0;
      gnt_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      done_id_r  <= '0;
      sign_r     <= 1'b0;
      bcd_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (win_found_s) begin
            gnt_r      <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
            busy_r     <= 1'b1;
            sign_cur_r <= win_word_s[DATA_W-1];
            mag_r      <= win_mag_s;
            cnt_r      <= 4'(ITER - 1);
            ptr_r      <= win_idx_s;
            id_r       <= win_idx_s;
            state_r    <= CONV;
          end else begin
            gnt_r  <= '0;
            busy_r <= 1'b0;
          end
        end
        CONV: begin
          gnt_r <= '0;
          // The iteration using mag[0] completes on this edge when cnt is 0.
          if (cnt_r == 4'd0) begin
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE: begin
          // busy stays high through the done cycle and drops back in IDLE.
          done_r    <= 1'b1;
          bcd_r     <= digits_s;
          sign_r    <= sign_cur_r;
          done_id_r <= id_r;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= '0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign done_id = done_id_r;
  assign sign    = sign_r;
  assign bcd     = bcd_r;

endmodule

// File: tb/tb_s12bcd_rr_ctrl.sv
// tb_s12bcd_rr_ctrl: self-checking bench for s12bcd_rr_ctrl. Directed scenarios
// followed by randomized request traffic, all compared against a behavioural
// model (decimal arithmetic for the result, round-robin scan for arbitration,
// fixed 14-cycle service slot per grant).
module tb_s12bcd_rr_ctrl;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [12*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 done;
  logic [IDW-1:0]       done_id;
  logic                 sign;
  logic [15:0]          bcd;

  s12bcd_rr_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .sign     (sign),
    .bcd      (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int cyc;
  int free_at;
  int ptr_m;
  int last_g;
  bit pend;
  int pend_done;
  int pend_id;
  bit pend_sign;
  logic [15:0] pend_bcd;

  logic [NREQ-1:0] exp_gnt;
  bit              exp_busy;
  bit              exp_done;
  int              exp_id;
  bit              exp_sign;
  logic [15:0]     exp_bcd;

  bit              rand_mode = 1'b0;
  logic [NREQ-1:0] hold_mask = '0;
  int              grant_log[$];
  int              grant_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input logic [11:0] w);
    int m;
    m = w[11] ? (4096 - int'(w)) : int'(w);
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic model_reset();
    free_at  = cyc + 1;
    ptr_m    = NREQ - 1;
    last_g   = -100;
    pend     = 1'b0;
    exp_gnt  = '0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_id   = 0;
    exp_sign = 1'b0;
    exp_bcd  = 16'h0000;
  endtask

  // Predict DUT outputs for the cycle following the next rising edge.
  task automatic predict();
    int e;
    int w;
    logic [11:0] word;
    e = cyc + 1;
    exp_done = 1'b0;
    if (pend && pend_done == e) begin
      exp_done = 1'b1;
      exp_id   = pend_id;
      exp_sign = pend_sign;
      exp_bcd  = pend_bcd;
      pend     = 1'b0;
    end
    exp_gnt = '0;
    if (e >= free_at && req != '0) begin
      w = -1;
      for (int off = 1; off <= NREQ; off++) begin
        if (w < 0 && req[(ptr_m + off) % NREQ]) w = (ptr_m + off) % NREQ;
      end
      exp_gnt   = '0;
      exp_gnt[w] = 1'b1;
      ptr_m     = w;
      last_g    = e;
      free_at   = e + 14;
      word      = req_data[w*12 +: 12];
      pend      = 1'b1;
      pend_done = e + 13;
      pend_id   = w;
      pend_sign = word[11];
      pend_bcd  = ref_bcd(word);
    end
    exp_busy = (e >= last_g) && (e <= last_g + 13);
  endtask

  task automatic check_outputs();
    chk("gnt",     32'(gnt),     32'(exp_gnt));
    chk("busy",    32'(busy),    32'(exp_busy));
    chk("done",    32'(done),    32'(exp_done));
    chk("done_id", 32'(done_id), 32'(exp_id));
    chk("sign",    32'(sign),    32'(exp_sign));
    chk("bcd",     32'(bcd),     32'(exp_bcd));
  endtask

  function automatic logic [11:0] rand_word();
    case ($urandom_range(7))
      0: return 12'h800;
      1: return 12'h7FF;
      2: return 12'h000;
      3: return 12'hFFF;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic rand_stim();
    for (int k = 0; k < NREQ; k++) begin
      if (!req[k]) begin
        if ($urandom_range(5) == 0) begin
          req[k] = 1'b1;
          req_data[k*12 +: 12] = rand_word();
        end
      end else begin
        if ($urandom_range(39) == 0) req[k] = 1'b0;
        else if ($urandom_range(19) == 0) req_data[k*12 +: 12] = rand_word();
      end
    end
  endtask

  // One clock: predict, pass the rising edge, check at the falling edge,
  // then let granted requesters release their request.
  task automatic step1();
    if (rand_mode) rand_stim();
    predict();
    @(negedge clk);
    cyc++;
    check_outputs();
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        grant_log.push_back(k);
        grant_cyc.push_back(cyc);
        if (!hold_mask[k]) req[k] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step1();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},  32'(gnt),     32'd0);
    chk({tag, "_busy"}, 32'(busy),    32'd0);
    chk({tag, "_done"}, 32'(done),    32'd0);
    chk({tag, "_id"},   32'(done_id), 32'd0);
    chk({tag, "_sign"}, 32'(sign),    32'd0);
    chk({tag, "_bcd"},  32'(bcd),     32'd0);
  endtask

  task automatic one_conv(input int k, input logic [11:0] w,
                          input logic [15:0] xbcd, input bit xsign, input string tag);
    req_data[k*12 +: 12] = w;
    req[k] = 1'b1;
    run(1);
    chk({tag, "_gnt"}, 32'(gnt), 32'(1 << k));
    run(13);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_bcd"},  32'(bcd), 32'(xbcd));
    chk({tag, "_sign"}, 32'(sign), 32'(xsign));
    chk({tag, "_id"},   32'(done_id), 32'(k));
    run(1);
  endtask

  initial begin
    cyc      = 0;
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    model_reset();

    // All four request from reset with data k*111.
    for (int k = 0; k < NREQ; k++) req_data[k*12 +: 12] = 12'(k * 111);
    req = 4'hF;
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    check_zero("rst");
    rst_n = 1'b1;
    model_reset();
    run(60);
    chk("p3_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("p3_order", 32'(grant_log[i]), 32'(i));
      for (int i = 1; i < 4; i++) chk("p3_gap", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd14);
    end
    chk("p3_last_bcd", 32'(bcd), 32'h0333);

    // Single positive and negative conversions, including range limits.
    one_conv(0, 12'h07B, 16'h0123, 1'b0, "p1");
    one_conv(1, 12'hF85, 16'h0123, 1'b1, "p2a");
    one_conv(1, 12'h800, 16'h2048, 1'b1, "p2b");
    one_conv(1, 12'h7FF, 16'h2047, 1'b0, "p2c");

    // Requesters 0 and 2 held after requester 1 was served last.
    grant_log.delete();
    grant_cyc.delete();
    hold_mask = 4'b0101;
    req_data[0 +: 12]  = 12'h015;
    req_data[24 +: 12] = 12'hC00;
    req = 4'b0101;
    run(56);
    hold_mask = '0;
    req = '0;
    chk("p4_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk("p4_g0", 32'(grant_log[0]), 32'd2);
      chk("p4_g1", 32'(grant_log[1]), 32'd0);
      chk("p4_g2", 32'(grant_log[2]), 32'd2);
      chk("p4_g3", 32'(grant_log[3]), 32'd0);
    end
    run(2);

    // Data changes after the grant edge do not affect the conversion.
    req_data[0 +: 12] = 12'h3E7;
    req[0] = 1'b1;
    run(1);
    chk("p5_gnt", 32'(gnt), 32'h1);
    run(3);
    req_data[0 +: 12] = 12'h001;
    run(10);
    chk("p5_done", 32'(done), 32'd1);
    chk("p5_bcd", 32'(bcd), 32'h0999);
    run(1);

    // Reset in the middle of a conversion.
    req_data[12 +: 12] = 12'h123;
    req[1] = 1'b1;
    run(1);
    run(6);
    rst_n = 1'b0;
    #1;
    check_zero("p6_async");
    req = 4'b1000;
    req_data[36 +: 12] = 12'h456;
    repeat (2) begin
      @(negedge clk);
      cyc++;
      check_zero("p6_hold");
    end
    rst_n = 1'b1;
    model_reset();
    run(1);
    chk("p6_gnt3", 32'(gnt), 32'h8);
    run(13);
    chk("p6_done", 32'(done), 32'd1);
    chk("p6_bcd", 32'(bcd), 32'h1110);
    chk("p6_id", 32'(done_id), 32'd3);
    run(1);

    // Reset again with 0 and 3 pending: pointer restart favours 0.
    rst_n = 1'b0;
    req = 4'b1001;
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    model_reset();
    run(1);
    chk("p6_gnt0", 32'(gnt), 32'h1);
    run(14);

    // Randomized traffic.
    rand_mode = 1'b1;
    run(3000);
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
